// File: rtl/generic_mux_fifo.sv
// N-channel FIFO bank merged onto one valid/ready stream by a round-robin arbiter.
// Optional sticky overflow flags are built when GENERIC_MUX_FIFO_OVERFLOW_EN is defined.
module generic_mux_fifo #(
  parameter int WIDTH    = 10,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [CHANNELS-1:0]                    i_valid,
  output logic [CHANNELS-1:0]                    o_ready,
  input  logic [CHANNELS*WIDTH-1:0]              i_data,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [WIDTH-1:0]                       o_data,
  output logic [$clog2(CHANNELS)-1:0]            o_channel,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]  o_count,
  output logic [CHANNELS-1:0]                    o_overflow
);

  localparam int CW   = $clog2(CHANNELS);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);
  localparam logic [CW-1:0]   LAST_CH = CW'(CHANNELS - 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                      state_reg, state_next;
  logic [CW-1:0]               last_grant_reg, last_grant_next;
  logic [CW-1:0]               lock_grant_reg, lock_grant_next;
  logic [CW-1:0]               rr_grant;
  logic [CW-1:0]               grant;
  logic                        handshake;
  logic [CHANNELS-1:0]         nonempty;
  logic [CHANNELS-1:0]         pop;
  logic [CHANNELS-1:0][WIDTH-1:0] head_data;

  // First non-empty channel strictly after 'last', wrapping modulo CHANNELS.
  function automatic logic [CW-1:0] rr_pick(input logic [CW-1:0] last,
                                            input logic [CHANNELS-1:0] req);
    logic [CW-1:0] pick;
    logic [CW-1:0] idx_c;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx   = (int'(last) + i) % CHANNELS;
      idx_c = CW'(idx);
      if (!found && req[idx_c]) begin
        pick  = idx_c;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] mem_reg [DEPTH];
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    rd_ptr_reg;
      logic [CNTW-1:0]  count_reg;
      logic             push;

      // Full is judged on the registered count only, so a full FIFO never
      // accepts even when it is being popped in the same cycle.
      assign push    = i_valid[gi] && (count_reg != FULL);
      assign pop[gi] = handshake && (grant == CW'(gi));

      always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
          mem_reg[wr_ptr_reg] <= i_data[gi*WIDTH +: WIDTH];
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
          end
          case ({push, pop[gi]})
            2'b10:   count_reg <= count_reg + CNTW'(1);
            2'b01:   count_reg <= count_reg - CNTW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      assign head_data[gi]               = mem_reg[rd_ptr_reg];
      assign nonempty[gi]                = (count_reg != '0);
      assign o_ready[gi]                 = (count_reg != FULL);
      assign o_count[gi*CNTW +: CNTW]    = count_reg;

`ifdef GENERIC_MUX_FIFO_OVERFLOW_EN
      logic overflow_reg;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          overflow_reg <= 1'b0;
        end else if (i_valid[gi] && (count_reg == FULL)) begin
          overflow_reg <= 1'b1;
        end
      end
      assign o_overflow[gi] = overflow_reg;
`else
      assign o_overflow[gi] = 1'b0;
`endif
    end
  endgenerate

  assign rr_grant = rr_pick(last_grant_reg, nonempty);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= LAST_CH;
      lock_grant_reg <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      lock_grant_reg <= lock_grant_next;
    end
  end

  // A stalled offer freezes the grant so later arrivals cannot steal it.
  always_comb begin
    state_next      = state_reg;
    lock_grant_next = lock_grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      ST_IDLE: begin
        if (o_valid && !i_ready) begin
          state_next      = ST_LOCKED;
          lock_grant_next = rr_grant;
        end
      end
      ST_LOCKED: begin
        if (i_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (handshake) begin
      last_grant_next = grant;
    end
  end

  always_comb begin
    grant     = (state_reg == ST_LOCKED) ? lock_grant_reg : rr_grant;
    o_valid   = |nonempty;
    handshake = o_valid && i_ready;
    o_channel = o_valid ? grant : '0;
    o_data    = o_valid ? head_data[grant] : '0;
  end

endmodule
